// File: rtl/cpu_mem_pkg.sv
// Shared types for the vector/scalar CPU data-memory port.
package cpu_mem_pkg;
    localparam int LANES  = 16;
    localparam int WORD_W = 32;

    typedef logic [LANES-1:0][WORD_W-1:0] lane_vec_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} memr_state_t;
endpackage

// File: rtl/vec_mem_responder_if.sv
// Request/response bundle between the CPU memory stage and the data-memory responder.
interface vec_mem_responder_if #(
    parameter int ADDR_W = 18
);
    import cpu_mem_pkg::*;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // request fields are only sampled on that edge. resp_valid is a single-cycle
    // completion pulse with no back-pressure; dataRead holds until the next load completes.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              memWrite;
    logic              vec_scalar;
    lane_vec_t         dataWrite;
    logic              resp_valid;
    lane_vec_t         dataRead;

    modport master (
        output req_valid, addr, memWrite, vec_scalar, dataWrite,
        input  req_ready, resp_valid, dataRead
    );

    modport slave (
        input  req_valid, addr, memWrite, vec_scalar, dataWrite,
        output req_ready, resp_valid, dataRead
    );
endinterface

// File: rtl/dmem_spram.sv
// Single-port synchronous word RAM with registered read data; no reset so it maps to block RAM.
module dmem_spram
    import cpu_mem_pkg::*;
#(
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
    input  logic [WORD_W-1:0]            i_wdata,
    output logic [WORD_W-1:0]            o_rdata
);
    logic [WORD_W-1:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/vec_mem_responder.sv
// Serialises one scalar or 16-lane vector load/store at a time onto a single-port word RAM.
module vec_mem_responder #(
    parameter int ADDR_W    = 18,
    parameter int MEM_WORDS = 4096,
    parameter int LANES     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    vec_mem_responder_if.slave       bus,
    output cpu_mem_pkg::memr_state_t o_dbg_state
);
    import cpu_mem_pkg::*;

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [4:0]  VEC_LAST = 5'(LANES - 1);
    localparam logic [3:0]  TOP_LANE = 4'(LANES - 1);

    memr_state_t       r_state;
    memr_state_t       w_next_state;
    logic [4:0]        r_beat;
    logic [AW-1:0]     r_base;
    logic              r_write;
    logic              r_vec;
    lane_vec_t         r_wdata;
    logic              r_rd_pend;
    logic [3:0]        r_rd_lane;
    lane_vec_t         r_load_buf;

    logic              w_req_ready;
    logic              w_resp_valid;
    logic              w_ram_we;
    logic              w_rd_issue;
    logic              w_accept;
    logic              w_last_beat;
    logic [3:0]        w_lane;
    logic [AW-1:0]     w_ram_addr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_rdata;
    logic              w_unused_addr;

    assign w_accept      = bus.req_valid & w_req_ready;
    assign w_last_beat   = r_vec ? (r_beat == VEC_LAST) : 1'b1;
    // Beat b serves lane 15-b at word base+b; the AW-bit add wraps at the end of RAM.
    assign w_lane        = TOP_LANE - r_beat[3:0];
    assign w_ram_addr    = r_base + AW'(r_beat);
    assign w_ram_wdata   = r_wdata[w_lane];
    assign w_unused_addr = ^{bus.addr[ADDR_W-1:AW+2], bus.addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next_state = ACCESS;
            ACCESS:  if (w_last_beat)   w_next_state = DRAIN;
            DRAIN:   w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_ram_we     = 1'b0;
        w_rd_issue   = 1'b0;
        case (r_state)
            IDLE:    w_req_ready  = 1'b1;
            ACCESS: begin
                w_ram_we   = r_write;
                w_rd_issue = ~r_write;
            end
            RESP:    w_resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base  <= '0;
            r_write <= 1'b0;
            r_vec   <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_base  <= bus.addr[AW+1:2];
            r_write <= bus.memWrite;
            r_vec   <= bus.vec_scalar;
            r_wdata <= bus.dataWrite;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_beat <= '0;
        else if (r_state == ACCESS) r_beat <= r_beat + 5'd1;
        else                       r_beat <= '0;
    end

    // RAM read data lands one cycle after the beat, so the lane pointer trails by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pend <= 1'b0;
            r_rd_lane <= '0;
        end else begin
            r_rd_pend <= w_rd_issue;
            r_rd_lane <= w_lane;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_buf <= '0;
        end else begin
            if (r_rd_pend) r_load_buf[r_rd_lane] <= w_rdata;
            if (r_state == DRAIN && !r_write && !r_vec) r_load_buf[LANES-2:0] <= '0;
        end
    end

    dmem_spram #(
        .MEM_WORDS(MEM_WORDS)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_rdata)
    );

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.dataRead   = r_load_buf;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder: latency, lane mapping, wrap, aliasing, reset abort, handshake.
module tb_vec_mem_responder;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    memr_state_t dbg_state;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_resp = 1'b0;
    int          dbl_resp = 0;

    vec_mem_responder_if #(.ADDR_W(18)) bus();

    vec_mem_responder #(
        .ADDR_W(18),
        .MEM_WORDS(4096),
        .LANES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.resp_valid && prev_resp) dbl_resp <= dbl_resp + 1;
        prev_resp <= bus.resp_valid;
    end

    function automatic lane_vec_t ramp(input logic [31:0] base);
        lane_vec_t v;
        for (int i = 0; i < 16; i++) v[i] = base + 32'(i);
        return v;
    endfunction

    function automatic lane_vec_t lane15(input logic [31:0] w);
        lane_vec_t v;
        v = '0;
        v[15] = w;
        return v;
    endfunction

    function automatic lane_vec_t rand_vec();
        lane_vec_t v;
        for (int i = 0; i < 16; i++) v[i] = $urandom;
        return v;
    endfunction

    task automatic drive_garbage(input logic valid);
        bus.req_valid  = valid;
        bus.addr       = 18'($urandom_range(0, 262143));
        bus.memWrite   = 1'($urandom_range(0, 1));
        bus.vec_scalar = 1'($urandom_range(0, 1));
        bus.dataWrite  = rand_vec();
    endtask

    // Issues one request and returns accept-edge-to-response latency in edges plus dataRead at RESP.
    task automatic do_req(input logic [17:0] a, input logic we, input logic vec,
                          input lane_vec_t wd, output int lat, output lane_vec_t rd);
        int j;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.addr       = a;
        bus.memWrite   = we;
        bus.vec_scalar = vec;
        bus.dataWrite  = wd;
        j = 0;
        while (!bus.req_ready && j < 50) begin
            @(negedge clk);
            j++;
        end
        if (!bus.req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout addr=%h got req_ready=0 exp=1", a);
        end
        @(posedge clk);
        @(negedge clk);
        drive_garbage(1'b0);
        j = 0;
        while (!bus.resp_valid && j < 40) begin
            @(negedge clk);
            j++;
        end
        lat = j + 1;
        total++;
        if (!bus.resp_valid) begin
            bad++;
            lat = -1;
            $display("FAIL resp_timeout addr=%h got resp_valid=0 exp=1", a);
        end
        rd = bus.dataRead;
    endtask

    task automatic test_reset();
        drive_garbage(1'b0);
        #2 rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
        total++;
        if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        total++;
        if (bus.dataRead !== '0) begin bad++; $display("FAIL rst_dataRead got=%h exp=0", bus.dataRead); end
        total++;
        if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_scalar_store_load();
        int lat;
        lane_vec_t rd;
        do_req(18'h00010, 1'b1, 1'b0, lane15(32'hDEADBEEF), lat, rd);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL scalar_store_latency got=%0d exp=3", lat); end
        do_req(18'h00010, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL scalar_load_latency got=%0d exp=3", lat); end
        total++;
        if (rd !== lane15(32'hDEADBEEF)) begin bad++; $display("FAIL scalar_load_data got=%h exp=%h", rd, lane15(32'hDEADBEEF)); end
    endtask

    task automatic test_vector();
        int lat;
        lane_vec_t rd;
        do_req(18'h00100, 1'b1, 1'b1, ramp(32'h1000), lat, rd);
        total++;
        if (lat !== 18) begin bad++; $display("FAIL vec_store_latency got=%0d exp=18", lat); end
        do_req(18'h00100, 1'b0, 1'b1, '0, lat, rd);
        total++;
        if (lat !== 18) begin bad++; $display("FAIL vec_load_latency got=%0d exp=18", lat); end
        total++;
        if (rd !== ramp(32'h1000)) begin bad++; $display("FAIL vec_load_data got=%h exp=%h", rd, ramp(32'h1000)); end
        // A store must leave the previous load's data visible.
        do_req(18'h00200, 1'b1, 1'b0, lane15(32'hCAFEF00D), lat, rd);
        total++;
        if (rd !== ramp(32'h1000)) begin bad++; $display("FAIL store_keeps_dataRead got=%h exp=%h", rd, ramp(32'h1000)); end
        do_req(18'h00104, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (rd !== lane15(32'h0000100E)) begin bad++; $display("FAIL scalar_after_vec got=%h exp=%h", rd, lane15(32'h0000100E)); end
        // Upper address bits beyond the RAM size alias back onto word 128.
        do_req(18'h10200, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (rd !== lane15(32'hCAFEF00D)) begin bad++; $display("FAIL addr_alias got=%h exp=%h", rd, lane15(32'hCAFEF00D)); end
    endtask

    task automatic test_wrap();
        int lat;
        lane_vec_t rd;
        do_req(18'h03FF0, 1'b1, 1'b1, ramp(32'h0), lat, rd);
        do_req(18'h00000, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (rd !== lane15(32'd11)) begin bad++; $display("FAIL wrap_word0 got=%h exp=%h", rd, lane15(32'd11)); end
        do_req(18'h03FFC, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (rd !== lane15(32'd12)) begin bad++; $display("FAIL wrap_wordlast got=%h exp=%h", rd, lane15(32'd12)); end
        do_req(18'h03FF0, 1'b0, 1'b1, '0, lat, rd);
        total++;
        if (rd !== ramp(32'h0)) begin bad++; $display("FAIL wrap_vec_load got=%h exp=%h", rd, ramp(32'h0)); end
    endtask

    task automatic test_unaligned();
        int lat;
        lane_vec_t rd;
        do_req(18'h00023, 1'b1, 1'b0, lane15(32'h12345678), lat, rd);
        do_req(18'h00020, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (rd !== lane15(32'h12345678)) begin bad++; $display("FAIL unaligned got=%h exp=%h", rd, lane15(32'h12345678)); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int j;
        lane_vec_t rd;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.addr       = 18'h00100;
        bus.memWrite   = 1'b0;
        bus.vec_scalar = 1'b1;
        j = 0;
        while (!bus.req_ready && j < 50) begin
            @(negedge clk);
            j++;
        end
        @(posedge clk);
        @(negedge clk);
        drive_garbage(1'b0);
        repeat (7) @(negedge clk);
        total++;
        if (dbg_state !== ACCESS) begin bad++; $display("FAIL abort_mid_access got=%0d exp=%0d", dbg_state, ACCESS); end
        rst = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_req_ready got=%b exp=1", bus.req_ready); end
        total++;
        if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL abort_resp_valid got=%b exp=0", bus.resp_valid); end
        total++;
        if (bus.dataRead !== '0) begin bad++; $display("FAIL abort_dataRead got=%h exp=0", bus.dataRead); end
        total++;
        if (dbg_state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(negedge clk);
        rst = 1'b1;
        do_req(18'h00200, 1'b0, 1'b0, '0, lat, rd);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL abort_next_latency got=%0d exp=3", lat); end
        total++;
        if (rd !== lane15(32'hCAFEF00D)) begin bad++; $display("FAIL abort_next_data got=%h exp=%h", rd, lane15(32'hCAFEF00D)); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ha[4];
        logic        hw[4];
        logic        hv[4];
        lane_vec_t   hd[4];
        lane_vec_t   he[4];
        int          nb[4];
        int          acc_cyc[4];
        lane_vec_t   exp_q[$];
        lane_vec_t   e;
        int          n_acc;
        int          n_resp;
        int          guard;
        ha = '{18'h00200, 18'h00100, 18'h00300, 18'h00300};
        hw = '{1'b0, 1'b0, 1'b1, 1'b0};
        hv = '{1'b0, 1'b1, 1'b0, 1'b0};
        nb = '{1, 16, 1, 1};
        hd[0] = '0;
        hd[1] = '0;
        hd[2] = lane15(32'h55AA55AA);
        hd[3] = '0;
        he[0] = lane15(32'hCAFEF00D);
        he[1] = ramp(32'h1000);
        he[2] = ramp(32'h1000);
        he[3] = lane15(32'h55AA55AA);
        n_acc = 0;
        n_resp = 0;
        guard = 0;
        @(negedge clk);
        while (n_resp < 4 && guard < 200) begin
            if (bus.resp_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_resp got=resp exp=none");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.dataRead !== e) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", n_resp, bus.dataRead, e); end
                end
                n_resp++;
            end
            if (bus.req_ready && n_acc < 4) begin
                bus.req_valid  = 1'b1;
                bus.addr       = ha[n_acc];
                bus.memWrite   = hw[n_acc];
                bus.vec_scalar = hv[n_acc];
                bus.dataWrite  = hd[n_acc];
                acc_cyc[n_acc] = cyc + 1;
                exp_q.push_back(he[n_acc]);
                n_acc++;
            end else begin
                drive_garbage(n_acc < 4);
            end
            @(negedge clk);
            guard++;
        end
        drive_garbage(1'b0);
        total++;
        if (n_resp != 4) begin bad++; $display("FAIL b2b_responses got=%0d exp=4", n_resp); end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != nb[i-1] + 3) begin
                bad++;
                $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], nb[i-1] + 3);
            end
        end
        @(negedge clk);
        total++;
        if (dbl_resp != 0) begin bad++; $display("FAIL resp_double_pulse got=%0d exp=0", dbl_resp); end
    endtask

    initial begin
        test_reset();
        test_scalar_store_load();
        test_vector();
        test_wrap();
        test_unaligned();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_mem_responder.md
# vec_mem_responder

Data-memory responder serving the vector/scalar CPU's load/store port. It accepts one request at a time: an 18-bit byte address, a write flag, a vector/scalar flag and 16×32-bit store data. It serialises each request onto a single-port synchronous word RAM and returns 16×32-bit load data with a one-cycle response pulse. It sits between the CPU memory stage and data storage, and replaces a combinational memory with a stall-capable handshake.

## Interface

Parameters:
- ADDR_W, 18: byte-address width; matches the CPU `addr` port.
- MEM_WORDS, 4096: number of 32-bit words in backing RAM; must be a power of two.
- LANES, 16: vector lanes; fixed at 16 for this CPU.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst, in, 1: reset, asynchronous and active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: responder can accept; high only in IDLE.
- addr, in, ADDR_W: byte address; word index is addr[ADDR_W-1:2]; addr[1:0] ignored.
- memWrite, in, 1: 1 = store, 0 = load.
- vec_scalar, in, 1: 1 = vector (16 words), 0 = scalar (lane 15 only).
- dataWrite, in, LANES×32: store data; lane 15 is the scalar lane.
- resp_valid, out, 1: one-cycle pulse; request complete.
- dataRead, out, LANES×32: load data; valid while resp_valid=1 and held until the next load completes.

## Operation

- The request is accepted on an edge where req_valid & req_ready. At acceptance, addr word index, memWrite, vec_scalar and dataWrite are captured. Inputs are ignored at all other times.
- Beat count N: 16 for vector, 1 for scalar.
- Lane mapping: beat b (0..N-1) accesses lane 15-b at word (base + b) mod MEM_WORDS. Base is the captured word index reduced mod MEM_WORDS.
- Store beat: writes the captured lane word to RAM.
- Load beat: issues a RAM read. Data returns one cycle later and is written into the load buffer for lane 15-b.
- Scalar load: buffer lanes 14..0 are cleared to 0. Vector load: all lanes are written.
- Store completion leaves dataRead unchanged.
- States:
  - IDLE: req_ready=1. On accept, go to ACCESS with beat=0.
  - ACCESS: one beat per cycle. After beat N-1, go to DRAIN.
  - DRAIN: one cycle; captures the last read word.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Address wrap: a vector at base MEM_WORDS-4 touches words MEM_WORDS-4..MEM_WORDS-1, then 0..11.
- Ordering is strictly sequential. A load following a store always observes the stored data.
- Reset (any state, including mid-ACCESS):
  - Returns to IDLE; beat=0.
  - resp_valid=0, req_ready=1, dataRead=0.
  - RAM contents are not cleared. Words already written by an aborted store remain written.

## Timing

- Reset values: req_ready=1, resp_valid=0, dataRead=0, state IDLE.
- Accept at edge E0. Then:
  - ACCESS occupies cycles E0..E0+N-1.
  - DRAIN occupies cycle E0+N.
  - resp_valid is high in the cycle after edge E0+N+1.
- Latency from accept edge to resp_valid: scalar 3 cycles, vector 18 cycles.
- req_ready is low from the accept edge until the return to IDLE after RESP.
- Next accept is possible 1 cycle after RESP. Throughput: one request per N+3 cycles.
- dataRead is updated no later than the edge that enters RESP, and is stable through RESP and afterwards.
- req_valid may stay high across RESP. It is accepted only when back in IDLE, so no double-accept is possible in RESP.

## Structure

- Package `cpu_mem_pkg`:
  - Constants LANES=16 and WORD_W=32.
  - `typedef logic [LANES-1:0][WORD_W-1:0] lane_vec_t`.
  - `typedef enum {IDLE, ACCESS, DRAIN, RESP} memr_state_t`.
- Sub-module `dmem_spram`: single-port synchronous RAM, MEM_WORDS×32, with we, addr and wdata inputs and a registered rdata output. It has no reset and is inferable as block RAM.
- Top level contains the FSM, 5-bit beat counter, request capture registers, read-lane pointer (delayed beat) and load buffer.

## Test plan

- Reset: assert rst=0 mid-vector-load at beat 7, then release. Required: req_ready=1, resp_valid=0, dataRead=0 immediately. A following scalar load from a pre-written word returns correct data.
- Scalar store then load: store addr=0x00010, data lane15=0xDEADBEEF, then load addr=0x00010. Required:
  - Each resp_valid arrives 3 cycles after its accept.
  - Load gives lane15=0xDEADBEEF and lanes 14..0 = 0.
- Vector round trip: store vector at addr=0x00100 with lane i = 0x1000+i, then vector load from the same address. Required:
  - resp_valid arrives 18 cycles after each accept.
  - dataRead lane i = 0x1000+i.
  - Scalar load of addr 0x00104 returns 0x100E in lane 15.
- Wrap-around: vector store at word MEM_WORDS-4 with lane i = i. Required: word 0 holds 11 (lane 15-4) and word MEM_WORDS-1 holds 12. A vector load from the same base returns lane i = i.
- Handshake: hold req_valid=1 continuously with alternating requests. Required:
  - Accepts are exactly N+3 cycles apart.
  - Input changes during ACCESS are ignored.
  - resp_valid is never high for 2 consecutive cycles.
- Unaligned: store scalar 0x12345678 at addr=0x00023, then load from 0x00020. Required: lane15=0x12345678.
